// File: rtl/seq_pace_timer.sv
// Pacing timer for the sequence-display phase: times show/blank intervals in prescaled ticks
// and owns the speed register that shortens the show interval as the game speeds up.
module seq_pace_timer #(
    parameter int TICK_DIV       = 500000,
    parameter int SPEED_W        = 5,
    parameter int SPEED_INIT     = 25,
    parameter int SPEED_STEP     = 1,
    parameter int SHOW_MIN_TICKS = 10,
    parameter int BLANK_TICKS    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               show_ready,
    input  logic               blank_ready,
    input  logic               reset_clk,
    input  logic               decr_clk,
    output logic               goBlank,
    output logic               goShow,
    output logic               clk_zero,
    output logic [SPEED_W-1:0] speed,
    output logic [1:0]         phase
);

    localparam int CNT_W = SPEED_W + 8;
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [SPEED_W-1:0] INIT_V    = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] STEP_V    = SPEED_W'(SPEED_STEP);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   BLANK_LEN = CNT_W'(BLANK_TICKS);
    localparam logic [CNT_W-1:0]   SHOW_MIN  = CNT_W'(SHOW_MIN_TICKS);

    // IDLE: waiting for a ready | SHOW_RUN/BLANK_RUN: timing | DONE: go held until controller moves
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHOW_RUN  = 2'd1,
        BLANK_RUN = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [CNT_W-1:0]   show_len;
    logic [SPEED_W-1:0] speed_next;

    assign tick     = (pre == PRE_LAST);
    assign show_len = CNT_W'(speed) + SHOW_MIN;
    assign phase    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            cnt     <= '0;
            goBlank <= 1'b0;
            goShow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pre     <= '0;
                    goBlank <= 1'b0;
                    goShow  <= 1'b0;
                    if (show_ready) begin
                        state <= SHOW_RUN;
                        cnt   <= show_len;
                    end else if (blank_ready) begin
                        state <= BLANK_RUN;
                        cnt   <= BLANK_LEN;
                    end
                end
                SHOW_RUN: begin
                    if (!show_ready && !blank_ready) begin
                        state <= IDLE;
                        pre   <= '0;
                    end else if (!show_ready) begin
                        state <= BLANK_RUN;
                        cnt   <= BLANK_LEN;
                        pre   <= '0;
                    end else if (tick) begin
                        pre <= '0;
                        if (cnt <= CNT_W'(1)) begin
                            state   <= DONE;
                            cnt     <= '0;
                            goBlank <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                BLANK_RUN: begin
                    // show_ready wins when both readies are high
                    if (show_ready) begin
                        state <= SHOW_RUN;
                        cnt   <= show_len;
                        pre   <= '0;
                    end else if (!blank_ready) begin
                        state <= IDLE;
                        pre   <= '0;
                    end else if (tick) begin
                        pre <= '0;
                        if (cnt <= CNT_W'(1)) begin
                            state  <= DONE;
                            cnt    <= '0;
                            goShow <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                DONE: begin
                    pre <= '0;
                    if (goBlank) begin
                        if (!show_ready) begin
                            goBlank <= 1'b0;
                            if (blank_ready) begin
                                state <= BLANK_RUN;
                                cnt   <= BLANK_LEN;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        if (show_ready) begin
                            goShow <= 1'b0;
                            state  <= SHOW_RUN;
                            cnt    <= show_len;
                        end else if (!blank_ready) begin
                            goShow <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        speed_next = speed;
        if (reset_clk)
            speed_next = INIT_V;
        else if (decr_clk)
            speed_next = (speed < STEP_V) ? '0 : speed - STEP_V;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed    <= INIT_V;
            clk_zero <= (INIT_V == '0);
        end else begin
            speed    <= speed_next;
            clk_zero <= (speed_next == '0);
        end
    end

endmodule

// File: tb/tb_seq_pace_timer.sv
// Bench for seq_pace_timer: directed scenarios then random readies/speed pulses,
// all checked against a timestamp-based model of interval expiry.
module tb_seq_pace_timer;

    localparam int TD   = 4;
    localparam int SW   = 5;
    localparam int SI   = 5;
    localparam int SS   = 2;
    localparam int SMIN = 2;
    localparam int BT   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          show_ready = 1'b0;
    logic          blank_ready = 1'b0;
    logic          reset_clk = 1'b0;
    logic          decr_clk = 1'b0;
    logic          goBlank;
    logic          goShow;
    logic          clk_zero;
    logic [SW-1:0] speed;
    logic [1:0]    phase;

    always #5 clk = ~clk;

    seq_pace_timer #(
        .TICK_DIV(TD), .SPEED_W(SW), .SPEED_INIT(SI), .SPEED_STEP(SS),
        .SHOW_MIN_TICKS(SMIN), .BLANK_TICKS(BT)
    ) dut (
        .clk(clk), .reset(reset), .show_ready(show_ready), .blank_ready(blank_ready),
        .reset_clk(reset_clk), .decr_clk(decr_clk), .goBlank(goBlank), .goShow(goShow),
        .clk_zero(clk_zero), .speed(speed), .phase(phase)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // model: mode 0 idle, 1 show, 2 blank, 3 done; expiry when cyc >= entry + len*TD
    int m_mode, m_entry, m_len, m_speed;
    bit m_gb, m_gs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_entry = 0; m_len = 0; m_speed = SI; m_gb = 0; m_gs = 0;
    endtask

    task automatic enter(input int mode);
        m_mode  = mode;
        m_entry = cyc;
        m_len   = (mode == 1) ? m_speed + SMIN : BT;
        m_gb    = 0;
        m_gs    = 0;
    endtask

    task automatic model_edge();
        cyc++;
        case (m_mode)
            0: if (show_ready) enter(1); else if (blank_ready) enter(2);
            1: begin
                if (!show_ready && !blank_ready) m_mode = 0;
                else if (!show_ready) enter(2);
                else if (cyc >= m_entry + m_len * TD) begin m_mode = 3; m_gb = 1; end
            end
            2: begin
                if (show_ready) enter(1);
                else if (!blank_ready) m_mode = 0;
                else if (cyc >= m_entry + m_len * TD) begin m_mode = 3; m_gs = 1; end
            end
            default: begin
                if (m_gb) begin
                    if (!show_ready) begin
                        if (blank_ready) enter(2);
                        else begin m_mode = 0; m_gb = 0; end
                    end
                end else begin
                    if (show_ready) enter(1);
                    else if (!blank_ready) begin m_mode = 0; m_gs = 0; end
                end
            end
        endcase
        if (reset_clk) m_speed = SI;
        else if (decr_clk) m_speed = (m_speed < SS) ? 0 : m_speed - SS;
    endtask

    task automatic compare_all();
        chk("goBlank", goBlank, m_gb);
        chk("goShow", goShow, m_gs);
        chk("phase", phase, m_mode);
        chk("speed", speed, m_speed);
        chk("clk_zero", clk_zero, m_speed == 0);
        chk("go_exclusive", goBlank & goShow, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    task automatic run_until(input bit want_blank, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((want_blank ? goBlank : goShow) !== 1'b1) && n < bound);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold;
        int r;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_goBlank", goBlank, 0);
        chk("rst_goShow", goShow, 0);
        chk("rst_speed", speed, 5);
        chk("rst_clk_zero", clk_zero, 0);
        chk("rst_phase", phase, 0);
        reset = 1'b0;

        show_ready = 1'b1;
        run_until(1'b1, 60, n);
        chk("show_latency", n, 1 + 7 * TD);
        repeat (5) step();
        chk("goBlank_held", goBlank, 1);
        show_ready = 1'b0; blank_ready = 1'b1;
        step();
        chk("blank_entry_phase", phase, 2);
        run_until(1'b0, 40, n);
        chk("blank_latency", n, BT * TD);
        blank_ready = 1'b0;
        step();
        chk("done_to_idle", phase, 0);

        decr_clk = 1'b1; step(); chk("decr1", speed, 3);
        step(); chk("decr2", speed, 1);
        step(); chk("decr3", speed, 0); chk("decr3_zero", clk_zero, 1);
        decr_clk = 1'b0;
        show_ready = 1'b1;
        run_until(1'b1, 40, n);
        chk("fast_latency", n, 1 + 2 * TD);
        show_ready = 1'b0;
        step();

        reset_clk = 1'b1; step(); reset_clk = 1'b0;
        decr_clk = 1'b1; repeat (2) step();
        chk("speed_one", speed, 1);
        reset_clk = 1'b1;
        step();
        chk("rclk_prio_speed", speed, 5);
        chk("rclk_prio_zero", clk_zero, 0);
        reset_clk = 1'b0; decr_clk = 1'b0;

        show_ready = 1'b1;
        step();
        repeat (10) step();
        show_ready = 1'b0;
        step();
        chk("abort_phase", phase, 0);
        chk("abort_goBlank", goBlank, 0);
        show_ready = 1'b1;
        run_until(1'b1, 60, n);
        chk("restart_latency", n, 1 + 7 * TD);
        show_ready = 1'b0;
        step();

        show_ready = 1'b1; blank_ready = 1'b1;
        step();
        chk("both_phase", phase, 1);
        repeat (40) step();
        chk("both_goShow", goShow, 0);
        show_ready = 1'b0; blank_ready = 1'b0;
        step();

        decr_clk = 1'b1; step(); decr_clk = 1'b0;
        show_ready = 1'b1;
        repeat (6) step();
        #2 reset = 1'b1;
        #1;
        chk("async_phase", phase, 0);
        chk("async_speed", speed, 5);
        chk("async_goBlank", goBlank, 0);
        chk("async_clk_zero", clk_zero, 0);
        model_reset();
        @(posedge clk);
        #1 compare_all();
        reset = 1'b0;
        step();
        show_ready = 1'b0;
        step();

        hold = 0;
        for (int i = 0; i < 700; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                show_ready  = (r <= 3) || (r == 9);
                blank_ready = (r >= 4 && r <= 7) || (r == 9);
                hold = $urandom_range(1, 40);
            end
            decr_clk  = ($urandom_range(0, 15) == 0);
            reset_clk = ($urandom_range(0, 19) == 0);
            step();
            hold--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
